retire_trace_fifo: RTL

Synthesizable retirement-trace recorder for the pipelined processor. It sits beside the writeback stage and samples one retirement per cycle: PC, register write, memory access and halt. Each retired instruction becomes a classified, numbered record in a parametrised FIFO. Records drain over a valid/ready port, and the block keeps cycle, instruction and drop counters, so a bench or debug port can consume the trace without probing pipeline internals.

---
 rtl/retire_trace_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_fifo
// Description : Writeback-side retirement trace recorder. Classifies and numbers
//               each retired instruction and queues it for a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32,
    parameter int REC_W = 70 + CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [15:0]      retire_pc,
    input  logic             reg_write,
    input  logic [2:0]       wr_reg,
    input  logic [15:0]      wr_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             halt,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [REC_W-1:0] rec_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             halted,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] c_kind_other = 3'd0;
    localparam logic [2:0] c_kind_reg   = 3'd1;
    localparam logic [2:0] c_kind_ld    = 3'd2;
    localparam logic [2:0] c_kind_st    = 3'd3;
    localparam logic [2:0] c_kind_stu   = 3'd4;
    localparam logic [2:0] c_kind_halt  = 3'd5;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;
    logic             halted_q, halted_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             retire_ev;
    logic             pop;
    logic             push;
    logic             drop;
    logic [2:0]       kind;
    logic             keep_reg;
    logic             keep_addr;
    logic             keep_mdata;
    logic [REC_W-1:0] new_rec;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign retire_ev = retire_valid && !halted_q;
    assign pop       = !fifo_empty && rec_ready;
    assign push      = retire_ev && (!fifo_full || pop);
    assign drop      = retire_ev && fifo_full && !pop;

    always_comb begin
        kind = c_kind_other;
        if (halt) begin
            kind = c_kind_halt;
        end else if (reg_write && mem_write) begin
            kind = c_kind_stu;
        end else if (reg_write && mem_read) begin
            kind = c_kind_ld;
        end else if (reg_write) begin
            kind = c_kind_reg;
        end else if (mem_write) begin
            kind = c_kind_st;
        end
    end

    assign keep_reg   = (kind == c_kind_reg) || (kind == c_kind_ld) || (kind == c_kind_stu);
    assign keep_addr  = (kind == c_kind_ld)  || (kind == c_kind_st) || (kind == c_kind_stu);
    assign keep_mdata = (kind == c_kind_st)  || (kind == c_kind_stu);

    // inum is the pre-increment instruction count, so drops leave gaps.
    assign new_rec = REC_W'({kind,
                             retire_pc,
                             keep_reg   ? wr_reg   : 3'd0,
                             keep_reg   ? wr_data  : 16'd0,
                             keep_addr  ? mem_addr : 16'd0,
                             keep_mdata ? mem_data : 16'd0,
                             inst_count_q});

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cycle_count_d = cycle_count_q;
        inst_count_d  = inst_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        halted_d      = halted_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (!halted_q) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        if (retire_ev) begin
            inst_count_d = inst_count_q + CNT_W'(1);
            if (halt) begin
                halted_d = 1'b1;
            end
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != {CNT_W{1'b1}}) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cycle_count_q <= '0;
            inst_count_q  <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cycle_count_q <= cycle_count_d;
            inst_count_q  <= inst_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            halted_q      <= halted_d;
        end
    end

    // Storage needs no reset: the output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
        end
    end

    assign rec_valid   = !fifo_empty;
    assign rec_data    = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign cycle_count = cycle_count_q;
    assign inst_count  = inst_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign halted      = halted_q;
    assign done        = halted_q && fifo_empty;

endmodule
`default_nettype wire
